pwm_led_array: RTL and testbench
================================

PWM_LED_ARRAY -- requirements
Module: pwm_led_array

Interface
REQ-001 SHALL have parameter CHANNELS, default 8: number of PWM LED outputs (1..16).
REQ-002 SHALL have parameter CNT_W, default 8: PWM counter and duty width; period = 2^CNT_W cycles.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port pwm_enable, input, 1: 1 = run PWM; 0 = counter held, LEDs off.
REQ-006 SHALL have port mode, input, 2: 00 STATIC, 01 BREATHE, 10 CHASE, 11 reserved (treated as STATIC).
REQ-007 SHALL have port wr_en, input, 1: duty register write strobe.
REQ-008 SHALL have port wr_addr, input, 4: channel index for the write.
REQ-009 SHALL have port wr_data, input, CNT_W: duty value for the write.
REQ-010 SHALL have port leds, output, CHANNELS: registered PWM outputs.
REQ-011 SHALL have port period_tick, output, 1: one-cycle pulse per completed period.

Function
REQ-012 SHALL, while pwm_enable=1, increment cnt by 1 per clock and wrap from 2^CNT_W-1 to 0; "wrap cycle" = enabled cycle with cnt = 2^CNT_W-1.
REQ-013 SHALL, while pwm_enable=0, load cnt with 0, drive leds to 0 next cycle, and hold period_tick at 0.
REQ-014 SHALL, on wr_en=1 with wr_addr < CHANNELS, write wr_data to duty_reg[wr_addr] at the clock edge; writes with wr_addr >= CHANNELS are ignored.
REQ-015 SHALL copy duty_reg into duty_act, and mode into mode_act, on every wrap cycle and on every cycle with pwm_enable=0; a write in the wrap cycle reaches duty_act one period later.
REQ-016 SHALL compute eff[i] by mode_act: STATIC eff[i] = duty_act[i]; BREATHE eff[i] = level for all i; CHASE eff[i] = duty_act[i] if i = pos, else 0.
REQ-017 SHALL register leds[i] <= pwm_enable AND (cnt < eff[i]), giving one-cycle latency; eff = 0 gives constant 0; eff = 2^CNT_W-1 gives high for 2^CNT_W-1 of 2^CNT_W cycles.
REQ-018 SHALL register period_tick <= 1 on the cycle after each wrap cycle, otherwise 0.
REQ-019 SHALL, in BREATHE, keep CNT_W-bit level and a two-state direction FSM (UP, DOWN), updated on each wrap cycle:
  - UP: level+1; at 2^CNT_W-1, go to DOWN with level held.
  - DOWN: level-1; at 0, go to UP with level held.
REQ-020 SHALL, in CHASE, advance pos by 1 on each wrap cycle, wrapping CHANNELS-1 -> 0.
REQ-021 SHALL, on a wrap cycle where the newly latched mode_act differs from the previous one, set level=0, direction=UP and pos=0 instead of updating them.
REQ-022 SHALL have no arithmetic overflow beyond the stated wraps; all compares are unsigned.

Reset
REQ-023 SHALL asynchronously clear, while rst=1:
  - cnt, duty_reg, duty_act, level, pos, leds and period_tick to 0;
  - direction to UP and mode_act to STATIC.
REQ-024 SHALL begin counting on the first enabled clock edge after rst deasserts; reset mid-period discards the partial period.

Structure
REQ-025 SHALL take mode encodings, the FSM state type and the period constant from package pwm_led_pkg.
REQ-026 SHALL instantiate CHANNELS copies of sub-module pwm_led_channel, each holding duty_reg, duty_act and the compare/output flop; shared counter, FSM, pos and tick logic sit in the top.

Verification
REQ-027 SHALL cover, with CNT_W=4 and STATIC: write duty 5 to ch0 and 0 to ch1, enable -> ch0 high 5 of 16 cycles, ch1 always 0, period_tick every 16 cycles.
REQ-028 SHALL cover: write ch2=15 in the wrap cycle while duty_act=3 -> 3-cycle pulse in the next period, 15-cycle pulses from the period after.
REQ-029 SHALL cover: BREATHE, CNT_W=4 -> level per period 0,1,...,15,15,14,...,0,0,1.
REQ-030 SHALL cover: CHASE, CHANNELS=4, all duties 8 -> only one LED pulses each period, in order 0,1,2,3,0.
REQ-031 SHALL cover: pwm_enable dropped mid-period -> leds 0 one cycle later and cnt restarts at 0 on re-enable; rst asserted mid-period -> all outputs 0 immediately.
REQ-032 SHALL cover: write to wr_addr=CHANNELS -> no duty change on any channel.

Source files
------------

// File: rtl/pwm_led_pkg.sv
// Shared encodings and helpers for the PWM LED array: mode codes,
// breathe-direction state type and the period length.
package pwm_led_pkg;

    typedef logic [1:0] mode_t;
    localparam mode_t MODE_STATIC  = 2'b00;
    localparam mode_t MODE_BREATHE = 2'b01;
    localparam mode_t MODE_CHASE   = 2'b10;
    localparam mode_t MODE_RSVD    = 2'b11;

    typedef logic [0:0] dir_t;
    localparam dir_t DIR_UP   = 1'b0;
    localparam dir_t DIR_DOWN = 1'b1;

    function automatic int unsigned period_len(input int unsigned cnt_w);
        return 32'd1 << cnt_w;
    endfunction

    // The reserved code behaves exactly like STATIC, including for change detection.
    function automatic mode_t mode_norm(input mode_t m);
        return (m == MODE_RSVD) ? MODE_STATIC : m;
    endfunction

endpackage

// File: rtl/pwm_led_if.sv
// Duty-register write port of the PWM LED array.
interface pwm_led_if #(parameter int CNT_W = 8);
    logic             wr_en;
    logic [3:0]       wr_addr;
    logic [CNT_W-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pwm_led_channel.sv
// One PWM output: duty register, period-aligned shadow copy and the
// registered compare against the shared counter.
module pwm_led_channel
    import pwm_led_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_enable,
    input  logic             load,
    input  logic             wr_sel,
    input  logic [CNT_W-1:0] wr_data,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] level,
    input  mode_t            mode_act,
    input  logic             chase_sel,
    output logic             led
);

    logic [CNT_W-1:0] duty_reg;
    logic [CNT_W-1:0] duty_act;
    logic [CNT_W-1:0] eff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_reg <= '0;
        end else if (wr_sel) begin
            duty_reg <= wr_data;
        end
    end

    // Shadow copy only moves at period boundaries so a pulse is never torn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_act <= '0;
        end else if (load) begin
            duty_act <= duty_reg;
        end
    end

    always_comb begin
        eff = duty_act;
        case (mode_act)
            MODE_BREATHE: eff = level;
            MODE_CHASE:   eff = chase_sel ? duty_act : '0;
            default:      eff = duty_act;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= 1'b0;
        end else begin
            led <= pwm_enable && (cnt < eff);
        end
    end

endmodule

// File: rtl/pwm_led_array.sv
// PWM LED array: shared period counter, breathe FSM, chase pointer and
// period tick, driving CHANNELS pwm_led_channel instances.
//
//   state    | meaning
//   DIR_UP   | breathe level rises by one per period, turns at max
//   DIR_DOWN | breathe level falls by one per period, turns at zero
module pwm_led_array
    import pwm_led_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwm_enable,
    input  mode_t               mode,
    pwm_led_if.slave            bus,
    output logic [CHANNELS-1:0] leds,
    output logic                period_tick
);

    localparam int unsigned      PERIOD  = period_len(CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);
    localparam int               POS_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(CHANNELS - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] level;
    logic [POS_W-1:0] pos;
    dir_t             dir;
    mode_t            mode_act;
    mode_t            mode_new;
    logic             wrap;
    logic             load;

    assign mode_new = mode_norm(mode);
    assign wrap     = pwm_enable && (cnt == CNT_MAX);
    assign load     = wrap || !pwm_enable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            period_tick <= 1'b0;
            mode_act    <= MODE_STATIC;
        end else begin
            cnt         <= pwm_enable ? cnt + 1'b1 : '0;
            period_tick <= wrap;
            if (load) begin
                mode_act <= mode_new;
            end
        end
    end

    // A mode switch at a period boundary restarts the animation from a known point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
            dir   <= DIR_UP;
            pos   <= '0;
        end else if (wrap) begin
            if (mode_new != mode_act) begin
                level <= '0;
                dir   <= DIR_UP;
                pos   <= '0;
            end else begin
                if (mode_act == MODE_BREATHE) begin
                    case (dir)
                        DIR_UP: begin
                            if (level == CNT_MAX) dir <= DIR_DOWN;
                            else level <= level + 1'b1;
                        end
                        default: begin
                            if (level == '0) dir <= DIR_UP;
                            else level <= level - 1'b1;
                        end
                    endcase
                end
                if (mode_act == MODE_CHASE) begin
                    pos <= (pos == POS_MAX) ? '0 : pos + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_led_channel #(.CNT_W(CNT_W)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .pwm_enable (pwm_enable),
            .load       (load),
            .wr_sel     (bus.wr_en && (bus.wr_addr == 4'(i))),
            .wr_data    (bus.wr_data),
            .cnt        (cnt),
            .level      (level),
            .mode_act   (mode_act),
            .chase_sel  (pos == POS_W'(i)),
            .led        (leds[i])
        );
    end

endmodule

// File: tb/tb_pwm_led_array.sv
// Directed bench for pwm_led_array with CNT_W=4, CHANNELS=4: per-period LED
// and tick bit patterns compared against hand-computed values.
module tb_pwm_led_array;
    import pwm_led_pkg::*;

    localparam int CH = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm_enable;
    mode_t         mode;
    logic [CH-1:0] leds;
    logic          period_tick;

    pwm_led_if #(.CNT_W(CW)) bus ();

    pwm_led_array #(.CHANNELS(CH), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_enable  (pwm_enable),
        .mode        (mode),
        .bus         (bus),
        .leds        (leds),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] pat [CH];
    logic [15:0] tpat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples one 16-cycle period at negedges; sample k shows the compare made at cnt=k.
    task automatic run_period(input int wr_at, input logic [3:0] a, input logic [3:0] d);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) pat[c][k] = leds[c];
            tpat[k] = period_tick;
            if (k == wr_at) begin
                bus.wr_addr = a;
                bus.wr_data = d;
                bus.wr_en   = 1'b1;
            end else if (k == wr_at + 1) begin
                bus.wr_en = 1'b0;
            end
        end
    endtask

    task automatic check_period(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3);
        check({tag, "_ch0"}, {16'h0, pat[0]}, {16'h0, e0});
        check({tag, "_ch1"}, {16'h0, pat[1]}, {16'h0, e1});
        check({tag, "_ch2"}, {16'h0, pat[2]}, {16'h0, e2});
        check({tag, "_ch3"}, {16'h0, pat[3]}, {16'h0, e3});
        check({tag, "_tick"}, {16'h0, tpat}, 32'h8000);
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        @(negedge clk);
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        int          lv;
        logic [15:0] e;

        rst         = 1'b1;
        pwm_enable  = 1'b0;
        mode        = MODE_STATIC;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        repeat (3) @(negedge clk);
        check("reset_leds", {28'h0, leds}, 32'h0);
        check("reset_tick", {31'h0, period_tick}, 32'h0);
        rst = 1'b0;

        // Setup while disabled; address 4 is out of range and must be dropped.
        wr(4'd0, 4'd5);
        wr(4'd1, 4'd0);
        wr(4'd2, 4'd3);
        wr(4'd3, 4'd9);
        wr(4'd4, 4'd15);
        repeat (2) @(negedge clk);
        check("disabled_leds", {28'h0, leds}, 32'h0);
        check("disabled_tick", {31'h0, period_tick}, 32'h0);

        pwm_enable = 1'b1;
        run_period(-1, 4'd0, 4'd0);
        check_period("static_p1", 16'h001F, 16'h0000, 16'h0007, 16'h01FF);

        // ch2 written during the wrap cycle: old duty for one more period.
        run_period(14, 4'd2, 4'd15);
        check_period("static_p2", 16'h001F, 16'h0000, 16'h0007, 16'h01FF);
        run_period(3, 4'd4, 4'd1);
        check_period("wrapwr_p3", 16'h001F, 16'h0000, 16'h0007, 16'h01FF);
        run_period(-1, 4'd0, 4'd0);
        check_period("wrapwr_p4", 16'h001F, 16'h0000, 16'h7FFF, 16'h01FF);

        // Drop enable mid-period.
        repeat (8) @(negedge clk);
        check("pre_disable_leds", {28'h0, leds}, 32'hC);
        pwm_enable = 1'b0;
        @(negedge clk);
        check("disable_leds_1cyc", {28'h0, leds}, 32'h0);
        check("disable_tick", {31'h0, period_tick}, 32'h0);
        repeat (3) @(negedge clk);
        check("disable_leds_hold", {28'h0, leds}, 32'h0);
        pwm_enable = 1'b1;
        run_period(-1, 4'd0, 4'd0);
        check_period("reenable", 16'h001F, 16'h0000, 16'h7FFF, 16'h01FF);

        // BREATHE: mode latched at the next wrap, level restarts at 0.
        mode = MODE_BREATHE;
        run_period(-1, 4'd0, 4'd0);
        check_period("breathe_switch", 16'h001F, 16'h0000, 16'h7FFF, 16'h01FF);
        for (int p = 0; p < 34; p++) begin
            lv = (p <= 15) ? p : (p <= 31) ? 31 - p : p - 32;
            e  = 16'((32'd1 << lv) - 1);
            run_period(-1, 4'd0, 4'd0);
            check_period($sformatf("breathe_p%0d", p), e, e, e, e);
        end

        // CHASE with all duties 8, written during the switch period.
        mode = MODE_CHASE;
        for (int c = 0; c < CH; c++) begin
            @(negedge clk);
            bus.wr_addr = 4'(c);
            bus.wr_data = 4'd8;
            bus.wr_en   = 1'b1;
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        repeat (11) @(negedge clk);
        for (int p = 0; p < 5; p++) begin
            run_period(-1, 4'd0, 4'd0);
            check_period($sformatf("chase_p%0d", p),
                         (p % 4 == 0) ? 16'h00FF : 16'h0000,
                         (p % 4 == 1) ? 16'h00FF : 16'h0000,
                         (p % 4 == 2) ? 16'h00FF : 16'h0000,
                         (p % 4 == 3) ? 16'h00FF : 16'h0000);
        end

        // Reset mid-period while ch1 is high.
        repeat (4) @(negedge clk);
        check("pre_reset_leds", {28'h0, leds}, 32'h2);
        rst = 1'b1;
        #1;
        check("midreset_leds", {28'h0, leds}, 32'h0);
        check("midreset_tick", {31'h0, period_tick}, 32'h0);
        repeat (2) @(negedge clk);
        check("reset_hold_leds", {28'h0, leds}, 32'h0);
        rst = 1'b0;
        run_period(2, 4'd0, 4'd3);
        check_period("post_reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        run_period(-1, 4'd0, 4'd0);
        check_period("post_reset_chase", 16'h0007, 16'h0000, 16'h0000, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
